// File: rtl/clk_pkg.sv
// Shared clock-tree constants for the car controller and UART blocks.
// Holds the default board/target frequencies and the half-period helper
// used to size each divider stage.
package clk_pkg;

   localparam int unsigned CLK_FREQ = 100_000_000;  // board oscillator, Hz
   localparam int unsigned MS_FREQ  = 1_000;        // power-on timing tick, Hz
   localparam int unsigned BTN_FREQ = 50;           // button debounce clock, Hz
   localparam int unsigned BAUD     = 9_600;        // UART baud rate

   // Input-clock cycles per half period of a square wave at f (truncated).
   function automatic int unsigned half_cnt(input int unsigned clk_f, input int unsigned f);
      return clk_f / (2 * f);
   endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One divider stage: counts HALF input cycles, then toggles its output.
// Output period is 2*HALF cycles at 50% duty; it starts low after reset.
// Ports:
//   clk      in   input clock, rising-edge
//   rst      in   asynchronous active-low reset
//   clk_out  out  registered divided square wave
module clk_div_stage #(
   parameter int unsigned HALF = 1
) (
   input  logic clk,
   input  logic rst,
   output logic clk_out
);

   localparam int unsigned CW = $clog2(HALF) + 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   if (HALF < 1) begin : g_half_chk
      $error("clk_div_stage: HALF must be at least 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      out_d = out_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
         out_d = ~out_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign clk_out = out_q;

endmodule

// File: rtl/clk_divider.sv
// Top of the clock tree: four independent free-running dividers off the
// board oscillator.
// Ports:
//   clk_ms   in   board clock, CLK_FREQ Hz
//   rst      in   asynchronous active-low reset
//   tick_ms  out  MS_FREQ square wave (power-on timing)
//   btnclk   out  BTN_FREQ square wave (button debounce)
//   clk_16x  out  16*BAUD square wave (UART oversample)
//   clk_x    out  BAUD square wave (UART bit clock)
module clk_divider #(
   parameter int unsigned CLK_FREQ = clk_pkg::CLK_FREQ,
   parameter int unsigned MS_FREQ  = clk_pkg::MS_FREQ,
   parameter int unsigned BTN_FREQ = clk_pkg::BTN_FREQ,
   parameter int unsigned BAUD     = clk_pkg::BAUD
) (
   input  logic clk_ms,
   input  logic rst,
   output logic tick_ms,
   output logic btnclk,
   output logic clk_16x,
   output logic clk_x
);

   import clk_pkg::*;

   localparam int unsigned HALF_MS  = half_cnt(CLK_FREQ, MS_FREQ);
   localparam int unsigned HALF_BTN = half_cnt(CLK_FREQ, BTN_FREQ);
   localparam int unsigned HALF_16X = half_cnt(CLK_FREQ, 16 * BAUD);
   localparam int unsigned HALF_X   = half_cnt(CLK_FREQ, BAUD);

   // clk_16x is deliberately not derived from clk_x; truncation error is accepted.
   clk_div_stage #(.HALF(HALF_MS)) u_tick_ms (
      .clk     (clk_ms),
      .rst     (rst),
      .clk_out (tick_ms)
   );

   clk_div_stage #(.HALF(HALF_BTN)) u_btnclk (
      .clk     (clk_ms),
      .rst     (rst),
      .clk_out (btnclk)
   );

   clk_div_stage #(.HALF(HALF_16X)) u_clk_16x (
      .clk     (clk_ms),
      .rst     (rst),
      .clk_out (clk_16x)
   );

   clk_div_stage #(.HALF(HALF_X)) u_clk_x (
      .clk     (clk_ms),
      .rst     (rst),
      .clk_out (clk_x)
   );

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: a scaled-down instance (HALF = 5/50/1/20)
// for edge-exact timing and reset behaviour, plus a default-parameter
// instance for the faster outputs' real periods.
module tb_clk_divider;

   logic clk_ms = 1'b0;
   logic rst    = 1'b0;

   logic tick_ms, btnclk, clk_16x, clk_x;
   logic d_tick_ms, d_btnclk, d_clk_16x, d_clk_x;

   int checks   = 0;
   int failures = 0;

   always #5 clk_ms = ~clk_ms;

   clk_divider #(
      .CLK_FREQ (1000),
      .MS_FREQ  (100),
      .BTN_FREQ (10),
      .BAUD     (25)
   ) dut (
      .clk_ms  (clk_ms),
      .rst     (rst),
      .tick_ms (tick_ms),
      .btnclk  (btnclk),
      .clk_16x (clk_16x),
      .clk_x   (clk_x)
   );

   clk_divider dut_def (
      .clk_ms  (clk_ms),
      .rst     (rst),
      .tick_ms (d_tick_ms),
      .btnclk  (d_btnclk),
      .clk_16x (d_clk_16x),
      .clk_x   (d_clk_x)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample just after it.
   task automatic tick();
      @(posedge clk_ms);
      #1;
   endtask

   task automatic release_rst();
      @(negedge clk_ms);
      rst = 1'b1;
   endtask

   initial begin
      int n16_toggles;
      int nx_toggles;
      logic p16, px;
      int d16_r1, d16_r2, dx_r1, dx_f1, dx_r2;
      logic pd16, pdx;

      // Reset held for three running clock cycles.
      rst = 1'b0;
      repeat (3) tick();
      check("rst_tick_ms", tick_ms, 0);
      check("rst_btnclk", btnclk, 0);
      check("rst_clk_16x", clk_16x, 0);
      check("rst_clk_x", clk_x, 0);
      check("rst_cnt_tick", dut.u_tick_ms.cnt_q, 0);
      check("rst_cnt_btn", dut.u_btnclk.cnt_q, 0);
      check("rst_cnt_16x", dut.u_clk_16x.cnt_q, 0);
      check("rst_cnt_x", dut.u_clk_x.cnt_q, 0);
      check("rst_def_clk_x", d_clk_x, 0);

      // Free run: output after edge k is (k / HALF) % 2.
      release_rst();
      n16_toggles = 0;
      nx_toggles  = 0;
      p16 = clk_16x;
      px  = clk_x;
      for (int k = 1; k <= 200; k++) begin
         tick();
         check($sformatf("tick_ms_e%0d", k), tick_ms, 32'((k / 5) % 2));
         check($sformatf("btnclk_e%0d", k), btnclk, 32'((k / 50) % 2));
         check($sformatf("clk_16x_e%0d", k), clk_16x, 32'(k % 2));
         check($sformatf("clk_x_e%0d", k), clk_x, 32'((k / 20) % 2));
         if (k <= 160) begin
            if (clk_16x !== p16) n16_toggles++;
            if (clk_x !== px) nx_toggles++;
         end
         p16 = clk_16x;
         px  = clk_x;
         if (k == 4)   check("tick_ms_low_e4", tick_ms, 0);
         if (k == 5)   check("tick_ms_rise_e5", tick_ms, 1);
         if (k == 9)   check("tick_ms_high_e9", tick_ms, 1);
         if (k == 10)  check("tick_ms_fall_e10", tick_ms, 0);
         if (k == 15)  check("tick_ms_rise_e15", tick_ms, 1);
         if (k == 19)  check("clk_x_low_e19", clk_x, 0);
         if (k == 20)  check("clk_x_rise_e20", clk_x, 1);
         if (k == 60)  check("clk_x_rise_e60", clk_x, 1);
         if (k == 49)  check("btnclk_low_e49", btnclk, 0);
         if (k == 50)  check("btnclk_rise_e50", btnclk, 1);
         if (k == 100) check("btnclk_fall_e100", btnclk, 0);
         if (k == 150) check("btnclk_rise_e150", btnclk, 1);
      end
      // Four clk_x periods (160 edges): 160 clk_16x toggles, 8 clk_x toggles.
      check("clk_16x_toggles_160", 32'(n16_toggles), 160);
      check("clk_x_toggles_160", 32'(nx_toggles), 8);

      // Mid-period reset with tick_ms high at edge 7.
      rst = 1'b0;
      repeat (2) tick();
      release_rst();
      repeat (7) tick();
      check("mid_tick_ms_high_e7", tick_ms, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_async_tick_ms", tick_ms, 0);
      check("mid_async_clk_16x", clk_16x, 0);
      check("mid_async_cnt_tick", dut.u_tick_ms.cnt_q, 0);
      repeat (2) tick();
      check("mid_hold_tick_ms", tick_ms, 0);
      check("mid_hold_clk_16x", clk_16x, 0);
      release_rst();
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("mid_restart_low_e%0d", k), tick_ms, 0);
      end
      tick();
      check("mid_restart_rise_e5", tick_ms, 1);

      // Default parameters: clk_16x HALF 325, clk_x HALF 5208 (104.16 us at 10 ns).
      rst = 1'b0;
      repeat (2) tick();
      release_rst();
      d16_r1 = 0;
      d16_r2 = 0;
      dx_r1  = 0;
      dx_f1  = 0;
      dx_r2  = 0;
      pd16   = d_clk_16x;
      pdx    = d_clk_x;
      for (int k = 1; k <= 16000; k++) begin
         tick();
         if (d_clk_16x && !pd16) begin
            if (d16_r1 == 0) d16_r1 = k;
            else if (d16_r2 == 0) d16_r2 = k;
         end
         if (d_clk_x && !pdx) begin
            if (dx_r1 == 0) dx_r1 = k;
            else if (dx_r2 == 0) dx_r2 = k;
         end
         if (!d_clk_x && pdx && dx_f1 == 0) dx_f1 = k;
         pd16 = d_clk_16x;
         pdx  = d_clk_x;
         if (dx_r2 != 0) break;
      end
      check("def_clk_16x_first_rise", 32'(d16_r1), 325);
      check("def_clk_16x_period", 32'(d16_r2 - d16_r1), 650);
      check("def_clk_x_first_rise", 32'(dx_r1), 5208);
      check("def_clk_x_high", 32'(dx_f1 - dx_r1), 5208);
      check("def_clk_x_period", 32'(dx_r2 - dx_r1), 10416);
      check("def_tick_ms_low", d_tick_ms, 0);
      check("def_btnclk_low", d_btnclk, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
